// File: rtl/pwd_seq_if.sv
// Handshake bundle for the password sequencer: operator pulses and switch digit in,
// lamp and status readback out.
interface pwd_seq_if;
  logic       cfm;
  logic       clr;
  logic       relock;
  logic [3:0] sw_pwd;
  logic [1:0] led;
  logic [1:0] tries_left;
  logic [1:0] digit_idx;
  logic       unlocked;
  logic       alarm;

  modport master (
    output cfm, clr, relock, sw_pwd,
    input  led, tries_left, digit_idx, unlocked, alarm
  );

  modport slave (
    input  cfm, clr, relock, sw_pwd,
    output led, tries_left, digit_idx, unlocked, alarm
  );
endinterface

// File: rtl/pwd_seq.sv
// Digit-by-digit password lock with retry limit and timed lockout.
// Define PWD_SEQ_CHANGE_EN to compile in the PROG state (password change while open).
module pwd_seq #(
  parameter int          DIGITS      = 4,
  parameter logic [15:0] INIT_PWD    = 16'h1909,
  parameter int          MAX_TRIES   = 3,
  parameter logic [31:0] LOCK_CYCLES = 32'd50_000_000
) (
  input  logic     clk,
  input  logic     rst,
  pwd_seq_if.slave bus
);
  localparam int         PW         = 4 * DIGITS;
  localparam logic [1:0] TRIES_INIT = 2'(MAX_TRIES);
  localparam logic [1:0] LAST_IDX   = 2'(DIGITS - 1);

`ifdef PWD_SEQ_CHANGE_EN
  typedef enum logic [2:0] {ENTRY, CHECK, OPEN, LOCKOUT, PROG} state_t;
`else
  typedef enum logic [2:0] {ENTRY, CHECK, OPEN, LOCKOUT} state_t;
`endif

  state_t      state_reg, state_next;
  logic [1:0]  led_reg, led_next;
  logic [1:0]  tries_reg, tries_next;
  logic [1:0]  idx_reg, idx_next;
  logic        unlocked_reg, unlocked_next;
  logic        alarm_reg, alarm_next;
  logic [15:0] pwd_reg, pwd_next;
  logic [31:0] lock_cnt_reg, lock_cnt_next;
  logic [3:0]  digit_reg  [0:3];
  logic [3:0]  digit_next [0:3];
  logic [15:0] entered;
  logic        match;

  for (genvar gi = 0; gi < 4; gi++) begin : g_entered
    assign entered[4*gi +: 4] = digit_reg[gi];
  end

  // Only the configured number of digits takes part in the comparison.
  assign match = (entered[PW-1:0] == pwd_reg[PW-1:0]);

`ifdef PWD_SEQ_CHANGE_EN
  logic [15:0] prog_word;
  always_comb begin
    prog_word = pwd_reg;
    for (int i = 0; i < DIGITS; i++)
      prog_word[4*i +: 4] = (2'(i) == idx_reg) ? bus.sw_pwd : digit_reg[i];
  end
`endif

  always_comb begin
    state_next    = state_reg;
    led_next      = led_reg;
    tries_next    = tries_reg;
    idx_next      = idx_reg;
    unlocked_next = unlocked_reg;
    alarm_next    = alarm_reg;
    pwd_next      = pwd_reg;
    lock_cnt_next = lock_cnt_reg;
    digit_next    = digit_reg;

    case (state_reg)
      ENTRY: begin
        if (bus.clr) begin
          idx_next = 2'd0;
          led_next = 2'b11;
          for (int i = 0; i < 4; i++) digit_next[i] = 4'd0;
        end else if (bus.cfm) begin
          digit_next[idx_reg] = bus.sw_pwd;
          led_next            = 2'b11;
          if (idx_reg == LAST_IDX) begin
            idx_next   = 2'd0;
            state_next = CHECK;
          end else begin
            idx_next = idx_reg + 2'd1;
          end
        end
      end
      CHECK: begin
        for (int i = 0; i < 4; i++) digit_next[i] = 4'd0;
        if (match) begin
          state_next    = OPEN;
          led_next      = 2'b10;
          unlocked_next = 1'b1;
          tries_next    = TRIES_INIT;
        end else if (tries_reg > 2'd1) begin
          state_next = ENTRY;
          led_next   = 2'b01;
          tries_next = tries_reg - 2'd1;
        end else begin
          // Counter holds cycles remaining after this one, so alarm lasts LOCK_CYCLES.
          state_next    = LOCKOUT;
          led_next      = 2'b00;
          tries_next    = 2'd0;
          alarm_next    = 1'b1;
          lock_cnt_next = LOCK_CYCLES - 32'd1;
        end
      end
      LOCKOUT: begin
        if (lock_cnt_reg == 32'd0) begin
          state_next = ENTRY;
          tries_next = TRIES_INIT;
          led_next   = 2'b11;
          alarm_next = 1'b0;
        end else begin
          lock_cnt_next = lock_cnt_reg - 32'd1;
        end
      end
      OPEN: begin
        if (bus.relock) begin
          state_next    = ENTRY;
          led_next      = 2'b11;
          unlocked_next = 1'b0;
          idx_next      = 2'd0;
        end
`ifdef PWD_SEQ_CHANGE_EN
        else if (bus.cfm) begin
          state_next = PROG;
          idx_next   = 2'd0;
          for (int i = 0; i < 4; i++) digit_next[i] = 4'd0;
        end
`endif
      end
`ifdef PWD_SEQ_CHANGE_EN
      PROG: begin
        if (bus.relock || bus.clr) begin
          idx_next = 2'd0;
          for (int i = 0; i < 4; i++) digit_next[i] = 4'd0;
          if (bus.relock) begin
            state_next    = ENTRY;
            led_next      = 2'b11;
            unlocked_next = 1'b0;
          end else begin
            state_next = OPEN;
          end
        end else if (bus.cfm) begin
          digit_next[idx_reg] = bus.sw_pwd;
          if (idx_reg == LAST_IDX) begin
            pwd_next   = prog_word;
            idx_next   = 2'd0;
            state_next = OPEN;
            for (int i = 0; i < 4; i++) digit_next[i] = 4'd0;
          end else begin
            idx_next = idx_reg + 2'd1;
          end
        end
      end
`endif
      default: state_next = ENTRY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ENTRY;
      led_reg      <= 2'b11;
      tries_reg    <= TRIES_INIT;
      idx_reg      <= 2'd0;
      unlocked_reg <= 1'b0;
      alarm_reg    <= 1'b0;
      pwd_reg      <= INIT_PWD;
      lock_cnt_reg <= 32'd0;
      for (int i = 0; i < 4; i++) digit_reg[i] <= 4'd0;
    end else begin
      state_reg    <= state_next;
      led_reg      <= led_next;
      tries_reg    <= tries_next;
      idx_reg      <= idx_next;
      unlocked_reg <= unlocked_next;
      alarm_reg    <= alarm_next;
      pwd_reg      <= pwd_next;
      lock_cnt_reg <= lock_cnt_next;
      for (int i = 0; i < 4; i++) digit_reg[i] <= digit_next[i];
    end
  end

  assign bus.led        = led_reg;
  assign bus.tries_left = tries_reg;
  assign bus.digit_idx  = idx_reg;
  assign bus.unlocked   = unlocked_reg;
  assign bus.alarm      = alarm_reg;
endmodule
